// File: rtl/ceespu_uart_rx_if.sv
// ----------------------------------------------------------------------------
// ceespu_uart_rx_if
// Memory-bus side of the ceespu UART receiver.
//   I_rxRead   : one-cycle pop strobe (CPU read of address 65528)
//   O_rxData   : last correctly received byte (feeds I_uartRxData)
//   O_rxValid  : buffer holds an unread byte
//   O_overrun  : sticky, a byte arrived while O_rxValid was already 1
//   O_frameErr : sticky, stop bit sampled low
//   O_busy     : receiver is not idle
// master = CPU/bus side, slave = receiver side.
// ----------------------------------------------------------------------------
interface ceespu_uart_rx_if;
    logic       I_rxRead;
    logic [7:0] O_rxData;
    logic       O_rxValid;
    logic       O_overrun;
    logic       O_frameErr;
    logic       O_busy;

    modport master (
        output I_rxRead,
        input  O_rxData, O_rxValid, O_overrun, O_frameErr, O_busy
    );

    modport slave (
        input  I_rxRead,
        output O_rxData, O_rxValid, O_overrun, O_frameErr, O_busy
    );
endinterface

// File: rtl/ceespu_uart_rx.sv
// ----------------------------------------------------------------------------
// ceespu_uart_rx
// 8N1 UART receiver for the ceespu with a one-entry receive buffer.
// Ports:
//   I_clk  : system clock, rising edge
//   I_rst  : synchronous active-high reset
//   I_rx   : asynchronous serial line, idle high
//   bus    : ceespu_uart_rx_if.slave (read strobe in; data, valid,
//            overrun, frame error and busy out)
// CLKS_PER_BIT = CLK_FREQ/BAUD is derived and must be at least 4.
// ----------------------------------------------------------------------------
module ceespu_uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic            I_rx,
    ceespu_uart_rx_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_clkCnt;
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_rxData;
    logic             r_rxValid;
    logic             r_overrun;
    logic             r_frameErr;
    logic             r_busy;

    logic             w_rxS;

    assign w_rxS = r_sync[1];

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state    <= S_IDLE;
            r_sync     <= 2'b11;
            r_clkCnt   <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_rxData   <= '0;
            r_rxValid  <= 1'b0;
            r_overrun  <= 1'b0;
            r_frameErr <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], I_rx};

            // Pop first; a stop-bit load further down overrides these,
            // so a read coinciding with a load leaves the new byte valid
            // with both flags cleared.
            if (bus.I_rxRead) begin
                r_rxValid  <= 1'b0;
                r_overrun  <= 1'b0;
                r_frameErr <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxS) begin
                        r_state  <= S_START;
                        r_clkCnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_clkCnt == C_HALF) begin
                        r_clkCnt <= '0;
                        r_bitCnt <= '0;
                        if (!w_rxS) begin
                            r_state <= S_DATA;
                        end else begin
                            // Line went back high before mid start bit.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (r_clkCnt == C_FULL) begin
                        r_clkCnt <= '0;
                        r_shift  <= {w_rxS, r_shift[7:1]};
                        if (r_bitCnt == 3'd7) begin
                            r_bitCnt <= '0;
                            r_state  <= S_STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (r_clkCnt == C_FULL) begin
                        r_clkCnt <= '0;
                        if (w_rxS) begin
                            r_rxData  <= r_shift;
                            r_rxValid <= 1'b1;
                            if (r_rxValid && !bus.I_rxRead) begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frameErr <= 1'b1;
                            r_state    <= S_BREAK;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + CNT_W'(1);
                    end
                end

                S_BREAK: begin
                    // Wait for the line to return high so a held-low line
                    // is not taken as a new start bit.
                    if (w_rxS) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.O_rxData   = r_rxData;
    assign bus.O_rxValid  = r_rxValid;
    assign bus.O_overrun  = r_overrun;
    assign bus.O_frameErr = r_frameErr;
    assign bus.O_busy     = r_busy;

endmodule

// File: tb/tb_ceespu_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_ceespu_uart_rx
// Scoreboard bench for ceespu_uart_rx with CLKS_PER_BIT = 16.
// The driver updates a byte-level model of the receive buffer and pushes the
// expected buffer state; the monitor pops and compares whenever the DUT ends
// a frame (O_busy falls), a read strobe takes effect, or a check is requested.
// ----------------------------------------------------------------------------
module tb_ceespu_uart_rx;

    localparam int CPB = 16;

    logic I_clk;
    logic I_rst;
    logic I_rx;
    logic chk_req;

    ceespu_uart_rx_if bus ();

    ceespu_uart_rx #(
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .I_clk (I_clk),
        .I_rst (I_rst),
        .I_rx  (I_rx),
        .bus   (bus)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    typedef struct {
        string      tag;
        logic [7:0] d;
        logic       v;
        logic       o;
        logic       f;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of the receive buffer
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;
    logic       m_ferr;

    task automatic cmp(input string what, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", what, got, exp, $time);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.d   = m_data;
        e.v   = m_valid;
        e.o   = m_ovr;
        e.f   = m_ferr;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic busy_prev;
        logic rd_prev;
        exp_t e;
        busy_prev = 1'b0;
        rd_prev   = 1'b0;
        forever begin
            @(negedge I_clk);
            if ((busy_prev === 1'b1 && bus.O_busy === 1'b0) || rd_prev || chk_req) begin
                if (sb.size() == 0) begin
                    cmp("unexpected_event", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    cmp({e.tag, "_data"},  {24'd0, bus.O_rxData}, {24'd0, e.d});
                    cmp({e.tag, "_valid"}, {31'd0, bus.O_rxValid}, {31'd0, e.v});
                    cmp({e.tag, "_ovr"},   {31'd0, bus.O_overrun}, {31'd0, e.o});
                    cmp({e.tag, "_ferr"},  {31'd0, bus.O_frameErr}, {31'd0, e.f});
                    cmp({e.tag, "_busy"},  {31'd0, bus.O_busy}, 32'd0);
                end
            end
            busy_prev = bus.O_busy;
            rd_prev   = bus.I_rxRead;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic gap(input int n);
        repeat (n) @(posedge I_clk);
    endtask

    // Drives one frame starting right after a rising edge. The stop bit is
    // sampled at the 155th edge after the start bit is driven (2 sync + 1
    // idle + 8 half-bit + 9*16), i.e. with a read driven at c == 154.
    // rst_at >= 0 pulses reset at that cycle index.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int low_hold,
                              input logic rd_at_stop, input int rst_at);
        logic [9:0] bits;
        int ncyc;
        int idx;
        bits = {stop_bit, b, 1'b0};
        ncyc = stop_bit ? 10 * CPB : 9 * CPB + low_hold;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge I_clk);
            #1;
            idx = c / CPB;
            I_rx = (c < 9 * CPB) ? bits[idx[3:0]] : stop_bit;
            bus.I_rxRead = (rd_at_stop && c == 154);
            I_rst = (c == rst_at);
            if (!stop_bit && c == 9 * CPB + low_hold - 4)
                cmp("break_hold_busy", {31'd0, bus.O_busy}, 32'd1);
        end
        @(posedge I_clk);
        #1;
        I_rx = 1'b1;
        bus.I_rxRead = 1'b0;
        I_rst = 1'b0;
        gap(6);
    endtask

    task automatic frame_ok(input logic [7:0] b, input logic rd_at_stop);
        if (rd_at_stop) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end else if (m_valid) begin
            m_ovr = 1'b1;
        end
        m_data  = b;
        m_valid = 1'b1;
        push_exp(rd_at_stop ? "frame_rd" : "frame");
        send_frame(b, 1'b1, 0, rd_at_stop, -1);
    endtask

    task automatic frame_bad(input logic [7:0] b, input int hold);
        m_ferr = 1'b1;
        push_exp("frame_err");
        send_frame(b, 1'b0, hold, 1'b0, -1);
    endtask

    task automatic do_read();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        push_exp("read");
        @(posedge I_clk);
        #1 bus.I_rxRead = 1'b1;
        @(posedge I_clk);
        #1 bus.I_rxRead = 1'b0;
        gap(2);
    endtask

    task automatic glitch();
        int k;
        push_exp("glitch");
        @(posedge I_clk);
        #1 I_rx = 1'b0;
        gap(4);
        #1 I_rx = 1'b1;
        k = 0;
        while (k < 10 && bus.O_busy !== 1'b0) begin
            @(negedge I_clk);
            k++;
        end
        cmp("glitch_busy_clear", {31'd0, bus.O_busy}, 32'd0);
        gap(4);
    endtask

    // Reset during data bit 4; upper nibble all ones keeps the rest of the
    // aborted frame high so it cannot look like a new start bit.
    task automatic reset_mid_frame(input logic [3:0] lo);
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        push_exp("rst_mid");
        send_frame({4'hF, lo}, 1'b1, 0, 1'b0, 5 * CPB + 5);
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        int r;
        I_rst        = 1'b1;
        I_rx         = 1'b1;
        bus.I_rxRead = 1'b0;
        chk_req      = 1'b0;
        m_data       = 8'h00;
        m_valid      = 1'b0;
        m_ovr        = 1'b0;
        m_ferr       = 1'b0;
        gap(3);
        #1 I_rst = 1'b0;
        push_exp("reset");
        chk_req = 1'b1;
        @(posedge I_clk);
        #1 chk_req = 1'b0;
        gap(3);

        frame_ok(8'hA5, 1'b0);
        do_read();

        glitch();

        frame_bad(8'h3C, 40);
        frame_ok(8'h11, 1'b0);
        do_read();

        frame_ok(8'h01, 1'b0);
        frame_ok(8'h02, 1'b0);
        do_read();

        frame_ok(8'h01, 1'b0);
        frame_ok(8'h02, 1'b1);
        do_read();

        reset_mid_frame(4'($urandom_range(0, 15)));
        frame_ok(8'h7E, 1'b0);
        do_read();

        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 7);
            case (r)
                0:       glitch();
                1:       frame_bad(8'($urandom), $urandom_range(20, 40));
                2:       frame_ok(8'($urandom), 1'b1);
                default: frame_ok(8'($urandom), 1'b0);
            endcase
            if ($urandom_range(0, 1) == 1) do_read();
            gap($urandom_range(0, 5));
        end

        gap(20);
        cmp("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

endmodule
